// File: rtl/dff_pre_bank_ctrl_pkg.sv
// dff_pre_bank_pkg
//   Shared definitions for the preset-capable register bank controller:
//   controller state encoding, INIT counter width and requester indices.
package dff_pre_bank_pkg;

  // Wide enough for INIT_CYCLES up to 15.
  localparam int unsigned INIT_CNT_W = 4;

  // Bit positions of the two write requesters in packed req/grant vectors.
  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_WRITE  = 2'd2,
    S_PRESET = 2'd3
  } state_t;

endpackage

// File: rtl/dff_pre_bank_ctrl_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter. On a tie the requester named by the
//   internal pointer wins. When upd is high the pointer moves to the
//   requester that did not win, so the loser of this round wins the next tie.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointer resets to 0)
//   req[1:0]    requests, bit REQ0 / REQ1
//   upd         a grant is being issued this cycle; advance the pointer
//   win[1:0]    one-hot winner (all zero when nothing is requested)
module rr_arb2
  import dff_pre_bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] win
);

  logic ptr;
  logic ptr_nxt;

  always_comb begin
    win = req;
    if (&req) begin
      win = ptr ? 2'b10 : 2'b01;
    end
  end

  // Winner 0 hands the tie-break to requester 1 and vice versa.
  always_comb begin
    ptr_nxt = ptr;
    if (upd) begin
      ptr_nxt = win[REQ0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/dff_pre_bank_ctrl.sv
// dff_pre_bank_ctrl
//   Sequencer for a WIDTH-bit bank of preset-capable D flipflops that capture
//   on every rising Clk edge. Supplies every bank D bit: hold (BankQ fed
//   back), write data from one of two round-robin arbitrated requesters, or
//   zero during INIT while BankPreset_n forces the bank to all ones.
// Ports:
//   Clk           clock, rising edge
//   _Reset        asynchronous active-low reset
//   Req0/Data0    requester 0 write request and data
//   Req1/Data1    requester 1 write request and data
//   PresetReq     preset the bank to all ones (sampled in IDLE)
//   BankQ         bank Q outputs (hold feedback)
//   BankD         bank D inputs
//   BankPreset_n  bank preset, active low
//   Gnt0/Gnt1     one-cycle write grants
//   Busy          high in every state except IDLE
module dff_pre_bank_ctrl
  import dff_pre_bank_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             _Reset,
  input  logic             Req0,
  input  logic [WIDTH-1:0] Data0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] Data1,
  input  logic             PresetReq,
  input  logic [WIDTH-1:0] BankQ,
  output logic [WIDTH-1:0] BankD,
  output logic             BankPreset_n,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Busy
);

  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);

  state_t                state;
  state_t                state_nxt;
  logic [INIT_CNT_W-1:0] init_cnt;
  logic [1:0]            req;
  logic [1:0]            win;
  logic                  arb_upd;
  logic [1:0]            gnt_nxt;
  logic                  gnt0_q;
  logic                  gnt1_q;

  assign req = {Req1, Req0};

  rr_arb2 u_arb (
    .clk   (Clk),
    .rst_n (_Reset),
    .req   (req),
    .upd   (arb_upd),
    .win   (win)
  );

  // Grants are computed alongside the IDLE->WRITE decision and registered,
  // so they are valid exactly for the WRITE cycle and free of glitches.
  always_comb begin
    state_nxt = state;
    arb_upd   = 1'b0;
    gnt_nxt   = '0;
    case (state)
      S_INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (PresetReq) begin
          state_nxt = S_PRESET;
        end else if (|req) begin
          state_nxt = S_WRITE;
          arb_upd   = 1'b1;
          gnt_nxt   = win;
        end
      end
      S_WRITE, S_PRESET: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge _Reset) begin
    if (!_Reset) begin
      state    <= S_INIT;
      init_cnt <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= (state == S_INIT) ? init_cnt + 1'b1 : '0;
      gnt0_q   <= gnt_nxt[REQ0];
      gnt1_q   <= gnt_nxt[REQ1];
    end
  end

  assign Gnt0         = gnt0_q;
  assign Gnt1         = gnt1_q;
  assign Busy         = (state != S_IDLE);
  assign BankPreset_n = !((state == S_INIT) || (state == S_PRESET));

  // In WRITE exactly one grant register is set; it selects the data source.
  always_comb begin
    BankD = BankQ;
    case (state)
      S_INIT:  BankD = '0;
      S_WRITE: BankD = gnt1_q ? Data1 : Data0;
      default: BankD = BankQ;
    endcase
  end

endmodule

// File: tb/tb_dff_pre_bank_ctrl.sv
// tb_dff_pre_bank_ctrl
//   Bench for dff_pre_bank_ctrl with a behavioural model of the flipflop bank
//   closing the BankD/BankQ loop. Directed scenarios use fixed expectations;
//   a randomized run is compared against a transaction-level reference.
module tb_dff_pre_bank_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned IC = 2;

  logic         Clk = 1'b0;
  logic         _Reset;
  logic         Req0, Req1, PresetReq;
  logic [W-1:0] Data0, Data1;
  logic [W-1:0] bank_q;
  logic [W-1:0] BankD;
  logic         BankPreset_n, Gnt0, Gnt1, Busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  // Preset-capable master-slave bank: preset low gives all ones at the edge.
  always @(posedge Clk) bank_q <= BankPreset_n ? BankD : '1;

  dff_pre_bank_ctrl #(
    .WIDTH       (W),
    .INIT_CYCLES (IC)
  ) dut (
    .Clk          (Clk),
    ._Reset       (_Reset),
    .Req0         (Req0),
    .Data0        (Data0),
    .Req1         (Req1),
    .Data1        (Data1),
    .PresetReq    (PresetReq),
    .BankQ        (bank_q),
    .BankD        (BankD),
    .BankPreset_n (BankPreset_n),
    .Gnt0         (Gnt0),
    .Gnt1         (Gnt1),
    .Busy         (Busy)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Counts INIT cycles from the current (first post-release) cycle onward.
  task automatic count_init(output int n);
    n = 0;
    for (int i = 0; i < 20 && BankPreset_n === 1'b0; i++) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    _Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0; PresetReq = 1'b0;
    Data0 = '0; Data1 = '0;
    tick(); tick(); tick();
    vectors++;
    if ({BankPreset_n, Gnt0, Gnt1, Busy} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_ctl {pre_n,g0,g1,busy} got=%b exp=0001", {BankPreset_n, Gnt0, Gnt1, Busy});
    end
    vectors++;
    if (BankD !== '0) begin
      miscompares++;
      $display("FAIL reset_bankd got=%h exp=00", BankD);
    end
    _Reset = 1'b1;
    count_init(n);
    vectors++;
    if (n !== IC) begin
      miscompares++;
      $display("FAIL init_len got=%0d exp=%0d", n, IC);
    end
    vectors++;
    if (bank_q !== 8'hFF || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL init_done bank=%h busy=%b exp bank=ff busy=0", bank_q, Busy);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    logic [W-1:0] exp_q;
    Data0 = 8'h11; Data1 = 8'h22; Req0 = 1'b1; Req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_q = (k % 2 == 0) ? 8'h11 : 8'h22;
      tick();
      vectors++;
      if ({Gnt1, Gnt0} !== exp_g || Busy !== 1'b1) begin
        miscompares++;
        $display("FAIL alt_gnt[%0d] {g1,g0}=%b busy=%b exp %b busy=1", k, {Gnt1, Gnt0}, Busy, exp_g);
      end
      if (k == 2) begin Req0 = 1'b0; Req1 = 1'b0; end
      tick();
      vectors++;
      if (bank_q !== exp_q || {Gnt1, Gnt0} !== 2'b00) begin
        miscompares++;
        $display("FAIL alt_bank[%0d] bank=%h g=%b exp bank=%h g=00", k, bank_q, {Gnt1, Gnt0}, exp_q);
      end
    end
  endtask

  task automatic test_single_write();
    logic saw_g1;
    saw_g1 = 1'b0;
    Req0 = 1'b1; Data0 = 8'hA5;
    tick();
    vectors++;
    if ({Gnt1, Gnt0} !== 2'b01 || BankD !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_gnt g=%b bankd=%h exp g=01 bankd=a5", {Gnt1, Gnt0}, BankD);
    end
    Req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (Gnt1 !== 1'b0 || Gnt0 !== 1'b0) saw_g1 = 1'b1;
    end
    vectors++;
    if (bank_q !== 8'hA5 || saw_g1 !== 1'b0) begin
      miscompares++;
      $display("FAIL single_hold bank=%h stray_gnt=%b exp bank=a5 stray_gnt=0", bank_q, saw_g1);
    end
  endtask

  task automatic test_preset_vs_write();
    Req0 = 1'b1; Data0 = 8'h00;
    tick();
    Req0 = 1'b0;
    tick();
    vectors++;
    if (bank_q !== 8'h00) begin
      miscompares++;
      $display("FAIL pre_setup bank=%h exp=00", bank_q);
    end
    PresetReq = 1'b1; Req1 = 1'b1; Data1 = 8'h5C;
    tick();
    vectors++;
    if ({BankPreset_n, Gnt0, Gnt1, Busy} !== 4'b0001 || BankD !== 8'h00) begin
      miscompares++;
      $display("FAIL pre_win ctl=%b bankd=%h exp ctl=0001 bankd=00", {BankPreset_n, Gnt0, Gnt1, Busy}, BankD);
    end
    PresetReq = 1'b0;
    tick();
    vectors++;
    if (bank_q !== 8'hFF || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_done bank=%h busy=%b exp bank=ff busy=0", bank_q, Busy);
    end
    tick();
    vectors++;
    if ({Gnt1, Gnt0} !== 2'b10) begin
      miscompares++;
      $display("FAIL pre_then_wr g=%b exp=10", {Gnt1, Gnt0});
    end
    Req1 = 1'b0;
    tick();
    vectors++;
    if (bank_q !== 8'h5C) begin
      miscompares++;
      $display("FAIL pre_then_wr_bank bank=%h exp=5c", bank_q);
    end
  endtask

  task automatic test_withdraw();
    logic saw_g0;
    saw_g0 = 1'b0;
    Req1 = 1'b1; Data1 = 8'h77;
    tick();
    vectors++;
    if ({Gnt1, Gnt0} !== 2'b10) begin
      miscompares++;
      $display("FAIL wd_gnt1 g=%b exp=10", {Gnt1, Gnt0});
    end
    Req1 = 1'b0; Req0 = 1'b1; Data0 = 8'h99;
    tick();
    Req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (Gnt0 !== 1'b0) saw_g0 = 1'b1;
      tick();
    end
    vectors++;
    if (saw_g0 !== 1'b0 || bank_q !== 8'h77) begin
      miscompares++;
      $display("FAIL withdraw saw_g0=%b bank=%h exp saw_g0=0 bank=77", saw_g0, bank_q);
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    Req0 = 1'b1; Data0 = 8'h3C;
    tick();
    vectors++;
    if (Gnt0 !== 1'b1) begin
      miscompares++;
      $display("FAIL rmw_gnt g0=%b exp=1", Gnt0);
    end
    #2 _Reset = 1'b0;
    #1;
    vectors++;
    if ({BankPreset_n, Gnt0, Gnt1, Busy} !== 4'b0001) begin
      miscompares++;
      $display("FAIL rmw_async ctl=%b exp=0001", {BankPreset_n, Gnt0, Gnt1, Busy});
    end
    Req0 = 1'b0;
    tick(); tick();
    _Reset = 1'b1;
    count_init(n);
    vectors++;
    if (n !== IC || bank_q !== 8'hFF || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rmw_restart init=%0d bank=%h busy=%b exp init=%0d bank=ff busy=0", n, bank_q, Busy, IC);
    end
  endtask

  // Reference: op is the transaction occupying the current cycle
  // (0 none, 1 write by 0, 2 write by 1, 3 preset); turn is who wins a tie.
  task automatic test_random();
    int           init_left, op, turn;
    logic [W-1:0] bank_exp;
    logic         drop0, drop1;
    logic [3:0]   exp_ctl, got_ctl;
    int           pick;
    _Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0; PresetReq = 1'b0;
    tick();
    _Reset = 1'b1;
    init_left = IC; op = 0; turn = 0; bank_exp = '1; drop0 = 1'b0; drop1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      exp_ctl = {op == 1, op == 2, !(init_left > 0 || op == 3), (init_left > 0 || op != 0)};
      got_ctl = {Gnt0, Gnt1, BankPreset_n, Busy};
      vectors++;
      if (got_ctl !== exp_ctl || bank_q !== bank_exp) begin
        miscompares++;
        $display("FAIL rand[%0d] {g0,g1,pre_n,busy}=%b bank=%h exp %b bank=%h", c, got_ctl, bank_q, exp_ctl, bank_exp);
      end
      if (Req0) begin
        if (drop0) begin Req0 = 1'b0; drop0 = 1'b0; end
        else if (op == 1) begin
          pick = int'($urandom_range(2, 0));
          if (pick == 0) Req0 = 1'b0;
          else if (pick == 1) drop0 = 1'b1;
        end else if ($urandom_range(31, 0) == 0) Req0 = 1'b0;
      end else if ($urandom_range(3, 0) == 0) begin
        Req0 = 1'b1; Data0 = W'($urandom);
      end
      if (Req1) begin
        if (drop1) begin Req1 = 1'b0; drop1 = 1'b0; end
        else if (op == 2) begin
          pick = int'($urandom_range(2, 0));
          if (pick == 0) Req1 = 1'b0;
          else if (pick == 1) drop1 = 1'b1;
        end else if ($urandom_range(31, 0) == 0) Req1 = 1'b0;
      end else if ($urandom_range(3, 0) == 0) begin
        Req1 = 1'b1; Data1 = W'($urandom);
      end
      PresetReq = ($urandom_range(11, 0) == 0);
      if (init_left > 0) begin
        init_left--;
        bank_exp = '1;
      end else if (op != 0) begin
        bank_exp = (op == 3) ? '1 : ((op == 1) ? Data0 : Data1);
        op = 0;
      end else if (PresetReq) begin
        op = 3;
      end else if (Req0 && Req1) begin
        op   = turn + 1;
        turn = 1 - turn;
      end else if (Req0) begin
        op = 1; turn = 1;
      end else if (Req1) begin
        op = 2; turn = 0;
      end
      tick();
    end
    Req0 = 1'b0; Req1 = 1'b0; PresetReq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single_write();
    test_preset_vs_write();
    test_withdraw();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
